// File: rtl/serial_subtractor_pkg.sv
// Shared types and constants for the bit-serial subtractor, plus a reference
// {bout, diff} computation that the bench can use.
package serial_subtractor_pkg;

    localparam int DEF_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_e;

    // Reference result for operands up to 32 bits: {bout, diff}, with diff
    // zero-extended to 32 bits. The borrow is the sign of the 33-bit difference.
    function automatic logic [32:0] ref_sub(input int unsigned w,
                                            input logic [31:0]  a,
                                            input logic [31:0]  b,
                                            input logic         bin);
        logic [31:0] mask;
        logic [32:0] full;
        mask = (w >= 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
        full = {1'b0, a & mask} - {1'b0, b & mask} - {32'd0, bin};
        return {full[32], full[31:0] & mask};
    endfunction

endpackage

// File: rtl/serial_subtractor_full_subtractor.sv
// One-bit subtraction cells: a half subtractor and a full subtractor made of
// two half subtractors chained through the difference, with OR'd borrows.

// Half subtractor: d = a - b, bo set when b exceeds a.
module half_subtractor (
    input  logic a,
    input  logic b,
    output logic d,
    output logic bo
);
    assign d  = a ^ b;
    assign bo = ~a & b;
endmodule

// Full subtractor: d = a - b - bin. The second stage borrows only when the
// first stage's difference is 0 and bin is 1, so the two borrows are exclusive.
module full_subtractor (
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic d,
    output logic bo
);
    logic d1, bo1, bo2;

    half_subtractor u_hs0 (.a(a),  .b(b),   .d(d1), .bo(bo1));
    half_subtractor u_hs1 (.a(d1), .b(bin), .d(d),  .bo(bo2));

    assign bo = bo1 | bo2;
endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: accepts a, b, bin, then resolves a - b - bin one bit
// per clock, LSB first, through a single full-subtractor cell with a
// registered borrow. Result is held until the consumer takes it.
module serial_subtractor
    import serial_subtractor_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             bout
);
    localparam int CW = $clog2(WIDTH + 1);

    localparam logic [1:0] S_IDLE = 2'(IDLE);
    localparam logic [1:0] S_BUSY = 2'(BUSY);
    localparam logic [1:0] S_DONE = 2'(DONE);

    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    logic [1:0]       state;
    logic [WIDTH-1:0] a_sh, b_sh;
    logic             br;
    logic [CW-1:0]    cnt;
    logic             d_bit, bo_bit;
    logic [WIDTH-1:0] diff_shift;

    full_subtractor u_fs (
        .a  (a_sh[0]),
        .b  (b_sh[0]),
        .bin(br),
        .d  (d_bit),
        .bo (bo_bit)
    );

    // New bit enters at the MSB so that after WIDTH shifts bit 0 sits at LSB.
    generate
        if (WIDTH == 1) begin : g_w1
            assign diff_shift = d_bit;
        end else begin : g_wn
            assign diff_shift = {d_bit, diff[WIDTH-1:1]};
        end
    endgenerate

    assign in_ready  = (state == S_IDLE);
    assign out_valid = (state == S_DONE);

    // Control FSM and datapath: load in IDLE, one bit per edge in BUSY,
    // hold the result in DONE until it is taken.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
            a_sh  <= '0;
            b_sh  <= '0;
            br    <= 1'b0;
            cnt   <= '0;
            diff  <= '0;
            bout  <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (in_valid) begin
                        a_sh  <= a;
                        b_sh  <= b;
                        br    <= bin;
                        cnt   <= '0;
                        diff  <= '0;
                        state <= S_BUSY;
                    end
                end
                S_BUSY: begin
                    diff <= diff_shift;
                    a_sh <= a_sh >> 1;
                    b_sh <= b_sh >> 1;
                    br   <= bo_bit;
                    cnt  <= cnt + 1'b1;
                    if (cnt == LAST) begin
                        bout  <= bo_bit;
                        state <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (out_ready) state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_serial_subtractor.sv
// Bench for serial_subtractor: WIDTH=8 directed tests (latency, wrap, hold,
// async reset), WIDTH=1 truth table, WIDTH=4 exhaustive back-to-back stream.
module tb_serial_subtractor;
    import serial_subtractor_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // WIDTH=8 instance
    logic       iv8 = 0, ir8, bin8 = 0, ov8, or8 = 1, bo8;
    logic [7:0] a8 = 0, b8 = 0, d8;
    // WIDTH=1 instance
    logic       iv1 = 0, ir1, bin1 = 0, ov1, or1 = 1, bo1;
    logic [0:0] a1 = 0, b1 = 0, d1;
    // WIDTH=4 instance
    logic       iv4 = 0, ir4, bin4 = 0, ov4, or4 = 1, bo4;
    logic [3:0] a4 = 0, b4 = 0, d4;

    serial_subtractor #(.WIDTH(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv8), .in_ready(ir8), .a(a8), .b(b8),
        .bin(bin8), .out_valid(ov8), .out_ready(or8), .diff(d8), .bout(bo8));
    serial_subtractor #(.WIDTH(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv1), .in_ready(ir1), .a(a1), .b(b1),
        .bin(bin1), .out_valid(ov1), .out_ready(or1), .diff(d1), .bout(bo1));
    serial_subtractor #(.WIDTH(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv4), .in_ready(ir4), .a(a4), .b(b4),
        .bin(bin4), .out_valid(ov4), .out_ready(or4), .diff(d4), .bout(bo4));

    task automatic chk(input string nm, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
        end
    endtask

    // Plain arithmetic: value a - b - bin, wrapped into [0, 2^w), borrow if negative.
    // Encoded as {bout, 32-bit diff}.
    function automatic longint model(input int w, input longint a, input longint b,
                                     input longint bin);
        longint m, r, bo;
        m = longint'(1) << w;
        r = a - b - bin;
        bo = 0;
        if (r < 0) begin
            r = r + m;
            bo = 1;
        end
        return (bo << 32) | r;
    endfunction

    function automatic longint pack(input logic bo, input logic [31:0] d);
        return (longint'(bo) << 32) | longint'(d);
    endfunction

    // Scoreboard: one FIFO per instance.
    typedef struct {
        longint r;
        int     acc;
    } exp_t;
    exp_t q0[$], q1[$], q2[$];
    int   ndone[3] = '{0, 0, 0};
    bit   prev_ov[3] = '{0, 0, 0};

    function automatic int qsize(input int i);
        case (i)
            0: return q0.size();
            1: return q1.size();
            default: return q2.size();
        endcase
    endfunction

    function automatic exp_t qfront(input int i);
        case (i)
            0: return q0[0];
            1: return q1[0];
            default: return q2[0];
        endcase
    endfunction

    task automatic qpush(input int i, input exp_t e);
        case (i)
            0: q0.push_back(e);
            1: q1.push_back(e);
            default: q2.push_back(e);
        endcase
    endtask

    task automatic qpop(input int i);
        case (i)
            0: void'(q0.pop_front());
            1: void'(q1.pop_front());
            default: void'(q2.pop_front());
        endcase
    endtask

    task automatic mon(input int i, input int w, input logic iv, input logic ir,
                       input logic [31:0] a, input logic [31:0] b, input logic bin,
                       input logic ov, input logic orr, input logic [31:0] diff,
                       input logic bout);
        exp_t e;
        if (ov) begin
            if (qsize(i) == 0) begin
                chk($sformatf("w%0d_spurious_out_valid", w), longint'(ov), 0);
            end else begin
                e = qfront(i);
                chk($sformatf("w%0d_result", w), pack(bout, diff), e.r);
                if (!prev_ov[i]) chk($sformatf("w%0d_latency", w), cyc - e.acc, w);
                if (orr) begin
                    qpop(i);
                    ndone[i]++;
                end
            end
        end
        if (iv && ir) begin
            e.r = model(w, longint'(a), longint'(b), longint'(bin));
            e.acc = cyc + 1;
            qpush(i, e);
        end
        prev_ov[i] = ov;
    endtask

    // Single compare process: samples all instances on the falling edge.
    always @(negedge clk) begin
        if (!rst_n) begin
            q0.delete();
            q1.delete();
            q2.delete();
            prev_ov = '{0, 0, 0};
        end else begin
            mon(0, 8, iv8, ir8, 32'(a8), 32'(b8), bin8, ov8, or8, 32'(d8), bo8);
            mon(1, 1, iv1, ir1, 32'(a1), 32'(b1), bin1, ov1, or1, 32'(d1), bo1);
            mon(2, 4, iv4, ir4, 32'(a4), 32'(b4), bin4, ov4, or4, 32'(d4), bo4);
        end
    end

    // One WIDTH=8 operation with literal expectations; optional 5-cycle hold.
    task automatic op8(input string nm, input logic [7:0] a, input logic [7:0] b,
                       input logic bin, input logic [7:0] ed, input logic eb,
                       input bit hold);
        int n;
        or8 = !hold;
        a8 = a; b8 = b; bin8 = bin; iv8 = 1;
        n = 0;
        while (!ir8 && n < 40) begin @(posedge clk); #1; n++; end
        @(posedge clk); #1;
        iv8 = 0;
        n = 0;
        while (!ov8 && n < 40) begin @(posedge clk); #1; n++; end
        chk({nm, "_latency"}, n, 8);
        chk({nm, "_diff"}, d8, ed);
        chk({nm, "_bout"}, bo8, eb);
        if (hold) begin
            for (int k = 0; k < 5; k++) begin
                iv8 = k[0]; a8 = 8'h3C; b8 = 8'h01;
                @(posedge clk); #1;
                chk({nm, "_hold_valid"}, ov8, 1);
                chk({nm, "_hold_in_ready"}, ir8, 0);
                chk({nm, "_hold_diff"}, d8, ed);
                chk({nm, "_hold_bout"}, bo8, eb);
            end
            iv8 = 0;
            or8 = 1;
        end
        @(posedge clk); #1;
        chk({nm, "_drain_valid"}, ov8, 0);
        chk({nm, "_drain_in_ready"}, ir8, 1);
    endtask

    logic [1:0] tt1 [8] = '{2'b00, 2'b11, 2'b11, 2'b10, 2'b01, 2'b00, 2'b00, 2'b11};

    initial begin
        int n;
        logic [8:0] v;
        // Pin the model and the package reference to hand-computed values.
        chk("pin_model_35_12", model(8, 'h35, 'h12, 0), 64'h0_0000_0023);
        chk("pin_model_00_01", model(8, 'h00, 'h01, 0), 64'h1_0000_00FF);
        chk("pin_model_80_80", model(8, 'h80, 'h80, 1), 64'h1_0000_00FF);
        chk("pin_model_FF_00", model(8, 'hFF, 'h00, 1), 64'h0_0000_00FE);
        chk("pin_model_w1", model(1, 0, 1, 1), 64'h1_0000_0000);
        chk("pin_ref_35_12", longint'(ref_sub(8, 32'h35, 32'h12, 1'b0)), 64'h0_0000_0023);
        chk("pin_ref_80_80", longint'(ref_sub(8, 32'h80, 32'h80, 1'b1)), 64'h1_0000_00FF);

        repeat (3) @(posedge clk);
        #1;
        chk("reset_in_ready", ir8, 1);
        chk("reset_out_valid", ov8, 0);
        chk("reset_diff", d8, 0);
        chk("reset_bout", bo8, 0);
        chk("reset_in_ready_w1", ir1, 1);
        chk("reset_in_ready_w4", ir4, 1);
        rst_n = 1;
        @(posedge clk); #1;

        // WIDTH=8 directed
        op8("t35_12", 8'h35, 8'h12, 1'b0, 8'h23, 1'b0, 0);
        op8("t00_01", 8'h00, 8'h01, 1'b0, 8'hFF, 1'b1, 0);
        op8("t80_80", 8'h80, 8'h80, 1'b1, 8'hFF, 1'b1, 1);
        op8("tFF_00", 8'hFF, 8'h00, 1'b1, 8'hFE, 1'b0, 0);
        @(posedge clk); #1;
        // Idle with in_valid low: nothing starts.
        chk("idle_stays", ir8, 1);

        // Async reset in the middle of BUSY.
        a8 = 8'h55; b8 = 8'h0F; bin8 = 0; iv8 = 1; or8 = 1;
        @(posedge clk); #1;
        iv8 = 0;
        @(posedge clk); @(posedge clk); #3;
        rst_n = 0;
        #1;
        chk("async_rst_out_valid", ov8, 0);
        chk("async_rst_in_ready", ir8, 1);
        chk("async_rst_diff", d8, 0);
        chk("async_rst_bout", bo8, 0);
        #10;
        rst_n = 1;
        @(posedge clk); #1;
        chk("post_rst_in_ready", ir8, 1);
        op8("t10_01", 8'h10, 8'h01, 1'b0, 8'h0F, 1'b0, 0);

        fork
            begin
                // WIDTH=1 truth table
                for (int i = 0; i < 8; i++) begin
                    v = 9'(i);
                    a1 = v[2]; b1 = v[1]; bin1 = v[0]; iv1 = 1;
                    n = 0;
                    while (!ir1 && n < 20) begin @(posedge clk); #1; n++; end
                    @(posedge clk); #1;
                    iv1 = 0;
                    n = 0;
                    while (!ov1 && n < 20) begin @(posedge clk); #1; n++; end
                    chk($sformatf("w1_tt%0d_latency", i), n, 1);
                    chk($sformatf("w1_tt%0d", i), {bo1, d1}, tt1[i]);
                    @(posedge clk); #1;
                end
            end
            begin
                // WIDTH=4 exhaustive, back-to-back
                int m;
                for (int i = 0; i < 512; i++) begin
                    v = 9'(i);
                    a4 = v[8:5]; b4 = v[4:1]; bin4 = v[0]; iv4 = 1;
                    m = 0;
                    while (!ir4 && m < 20) begin @(posedge clk); #1; m++; end
                    @(posedge clk); #1;
                end
                iv4 = 0;
            end
        join
        repeat (20) @(posedge clk);
        #1;
        chk("w1_count", ndone[1], 8);
        chk("w4_count", ndone[2], 512);
        chk("w4_queue_empty", qsize(2), 0);
        chk("w8_queue_empty", qsize(0), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/serial_subtractor.md
Name: serial_subtractor

Overview:
- Bit-serial, multi-cycle subtractor.
- Accepts two WIDTH-bit operands and a borrow-in, then computes a - b - bin LSB-first, one bit per clock.
- Each bit uses a full-subtractor cell built from two half subtractors, with a registered borrow.
- Presents the difference and borrow-out with a valid/ready handshake. Used where area matters more than latency, directly downstream of the combinational difference/borrow cells.

Parameters:
- WIDTH, 8, operand and result width in bits (WIDTH >= 1).

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  operands a, b, bin are valid.
- in_ready  output  1  block can accept operands.
- a  input  WIDTH  minuend.
- b  input  WIDTH  subtrahend.
- bin  input  1  borrow-in.
- out_valid  output  1  diff/bout valid.
- out_ready  input  1  consumer accepts result.
- diff  output  WIDTH  (a - b - bin) mod 2^WIDTH.
- bout  output  1  final borrow; 1 iff a < b + bin (unsigned).

Behaviour:
- One clock, clk. Reset rst_n is asynchronous, active-low.
- Reset values: state=IDLE, in_ready=1, out_valid=0, diff=0, bout=0. Internal shift registers, borrow register and counter are all 0.
- FSM states: IDLE, BUSY, DONE.
- IDLE:
  - in_ready=1, out_valid=0.
  - On a clock edge with in_valid&&in_ready: load a_sh<=a, b_sh<=b, br<=bin, cnt<=0, diff<=0; go to BUSY.
- BUSY:
  - in_ready=0; in_valid is ignored.
  - Each edge:
    - d = a_sh[0]^b_sh[0]^br
    - bo = (~a_sh[0]&b_sh[0]) | (~(a_sh[0]^b_sh[0])&br)
    - diff <= {d, diff[WIDTH-1:1]}; a_sh, b_sh shift right by 1; br <= bo; cnt <= cnt+1.
  - When cnt==WIDTH-1 at the edge: the last bit is shifted in, bout<=bo, go to DONE.
- DONE:
  - out_valid=1; diff and bout are held stable; in_ready=0.
  - On an edge with out_ready=1: go to IDLE.
  - The result registers keep their value until the next load. Only out_valid drops.
- Latency: the operand handshake at edge k gives out_valid=1 after edge k+WIDTH. Throughput is one result per WIDTH+2 cycles minimum (accept, WIDTH bits, drain).
- No overlap: a new operand cannot be accepted in the same cycle a result is drained. in_ready rises in the cycle after the out handshake.
- out_ready while not DONE: no effect.
- in_valid deasserted in IDLE: the block stays in IDLE. Holding values is not required of the producer after acceptance.
- WIDTH=1: BUSY lasts exactly one cycle (cnt==0==WIDTH-1).
- Counter width: $clog2(WIDTH+1); it never wraps within an operation.
- Reset asserted mid-operation (BUSY or DONE): immediate abort, with all outputs and state at their reset values. After release the block is in IDLE with in_ready=1, and the partial result is discarded.
- Arithmetic wrap-around: diff is always modulo 2^WIDTH. Underflow is flagged only via bout.

Decomposition:
- Shared package:
  - state enum {IDLE, BUSY, DONE}
  - default WIDTH constant
  - a function computing reference {bout, diff} for the bench
- One natural sub-module: full_subtractor (a, b, bin -> d, bo), built from two half-subtractor instances plus an OR gate. It is instantiated once for the serial bit slice.

Test Plan:
- WIDTH=8, a=0x35, b=0x12, bin=0 -> out_valid exactly 8 cycles after accept; diff=0x23, bout=0.
- a=0x00, b=0x01, bin=0 -> diff=0xFF, bout=1. Then a=0x80, b=0x80, bin=1 -> diff=0xFF, bout=1. Then a=0xFF, b=0x00, bin=1 -> diff=0xFE, bout=0.
- Backpressure: hold out_ready=0 for 5 cycles after out_valid -> out_valid stays 1, diff/bout are stable, in_ready=0, and in_valid pulses are ignored. Raise out_ready -> next cycle out_valid=0, in_ready=1.
- Assert rst_n=0 asynchronously (mid-cycle) at BUSY cycle 3 -> outputs are zero immediately. After release in_ready=1; a new op a=0x10, b=0x01 -> diff=0x0F, bout=0.
- WIDTH=1 instance: all 8 (a, b, bin) combinations -> results match the full-subtractor truth table, with out_valid 1 cycle after accept.
- WIDTH=4 exhaustive: all 512 (a, b, bin) combinations, back-to-back with out_ready=1 -> every {bout, diff} equals the package reference, and no result is lost or duplicated.
